hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  HI/LO register file with its own multi-cycle multiply/divide engine for the EX stage.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, computes over several cycles and commits {HI,LO}
//  atomically. Holds busy so the hazard unit stalls MFHI/MFLO and further HI/LO ops.
//  An in-flight operation is abandoned on a pipeline flush (exception/eret).
// PARAMETERS
//  DATA_W   32  operand, HI and LO width (>=8)
//  MUL_LAT  2   multiply latency in cycles, accept edge to commit edge (>=1)
// PORTS
//  clk      in   1         clock
//  rst      in   1         synchronous, active-high reset
//  start    in   1         request valid; accepted only when busy==0
//  op       in   3         operation code from the shared package
//  a        in   DATA_W    rs operand (dividend / multiplicand / MTHI-MTLO data)
//  b        in   DATA_W    rt operand (divisor / multiplier)
//  flush    in   1         abort the in-flight op; no HI/LO write
//  busy     out  1         MUL or DIV in progress
//  done     out  1         1-cycle pulse: new HI/LO visible in this cycle
//  hi_o     out  DATA_W    architectural HI
//  lo_o     out  DATA_W    architectural LO
// BEHAVIOUR
//  Reset: hi_o=0, lo_o=0, busy=0, done=0, FSM=IDLE; dominates all other inputs.
//  FSM: IDLE -> MUL (MULT/MULTU accepted) | DIV (DIV/DIVU accepted); MUL/DIV -> IDLE at commit or flush.
//  Accept edge E0: start=1 && busy==0 && flush==0. Operands and op are latched at E0.
//  MTHI/MTLO: write hi_o/lo_o at E0 and pulse done in the following cycle; busy stays 0; other register unchanged.
//  MULT/MULTU: 2*DATA_W-bit product; {HI,LO}<=product at edge E0+MUL_LAT.
//  DIV/DIVU: radix-2 restoring divide on magnitudes, DATA_W iterations plus 1 sign-fix cycle.
//  DIV/DIVU commit at edge E0+DATA_W+1; LO=quotient, HI=remainder.
//  Signed divide: quotient negated iff sign(a)!=sign(b); remainder takes sign(a).
//  DIV of MIN/-1 gives LO=MIN, HI=0. Divide by zero (b==0) keeps full latency; HI=a, LO=all ones.
//  busy=1 from the cycle after E0 through the commit edge, and 0 in the done cycle.
//  done=1 for exactly one cycle, after the commit edge.
//  start while busy: ignored; no queueing.
//  flush: FSM returns to IDLE at the next edge and HI/LO are not written. done stays 0.
//  flush outranks start and commit in the same cycle.
//  Unknown op codes with start=1 are ignored; busy stays 0.
// STRUCTURE
//  Shared package hilo_pkg: op encodings OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3,
//  OP_MTHI=4, OP_MTLO=5; FSM state type {IDLE, MUL, DIV}.
//  Sub-module div_iter: unsigned radix-2 core (start, dividend, divisor -> quotient, remainder, valid).
//  Sign handling is done in the parent. Multiply is a product register delayed MUL_LAT-1 stages.
// TESTING
//  1. Reset, then MTHI a=0x12345678 -> hi_o=0x12345678 with done 1 cycle later; lo_o stays 0.
//  2. MULT a=0xFFFFFFFE(-2) b=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA at E0+2. MULTU on the same operands -> HI=0x2, LO=0xFFFFFFFA.
//  3. DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at E0+33. busy high for exactly 33 cycles.
//  4. DIVU a=100 b=0 -> HI=100, LO=0xFFFFFFFF. DIV a=0x80000000 b=-1 -> LO=0x80000000, HI=0.
//  5. DIV in flight, flush at cycle 10 -> busy=0 next cycle, no done, and HI/LO keep their prior values.
//     Then issue MULTU 7x6 together with a second start while busy (second start ignored) -> LO=42.
//  6. rst asserted mid-DIV -> all outputs 0 next cycle. flush+start in the same cycle -> nothing accepted.

Source files
------------

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// hilo_pkg : operation codes and FSM state type shared by the HI/LO unit
// Revision : 1.0
// ============================================================================
package hilo_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// div_iter : unsigned radix-2 restoring divider, one quotient bit per cycle
// Revision : 1.0
// ============================================================================
module div_iter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o,
   output logic              valid_o
);

   localparam int              CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] ITERS = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              run_q, run_d;
   logic              valid_q, valid_d;
   logic [DATA_W:0]   w_shifted;
   logic [DATA_W:0]   w_diff;

   // Dividend bits shift out of the quotient register into the remainder.
   assign w_shifted = {rem_q, quo_q[DATA_W-1]};
   assign w_diff    = w_shifted - {1'b0, dvs_q};

   always_comb begin
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      valid_d = 1'b0;
      if (abort_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         quo_d = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
         cnt_d = ITERS;
         run_d = 1'b1;
      end else if (run_q) begin
         quo_d = {quo_q[DATA_W-2:0], ~w_diff[DATA_W]};
         rem_d = w_diff[DATA_W] ? w_shifted[DATA_W-1:0] : w_diff[DATA_W-1:0];
         cnt_d = cnt_q - ONE;
         if (cnt_q == ONE) begin
            run_d   = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         valid_q <= valid_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign valid_o     = valid_q;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// hilo_muldiv_unit : HI/LO registers with multi-cycle multiply/divide engine
// Revision : 1.0
// ============================================================================
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int               CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d;
   logic [2*DATA_W-1:0] prod_q, prod_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                qneg_q, qneg_d, rneg_q, rneg_d, bzero_q, bzero_d;

   logic                w_signed, w_a_neg, w_b_neg, w_div_start, w_div_valid;
   logic [2*DATA_W-1:0] w_a_ext, w_b_ext, w_prod;
   logic [DATA_W-1:0]   w_a_mag, w_b_mag, w_quo, w_rem;

   // Extending to full product width lets one unsigned multiplier serve both signednesses.
   assign w_signed = (op == OP_MULT) || (op == OP_DIV);
   assign w_a_neg  = w_signed & a[DATA_W-1];
   assign w_b_neg  = w_signed & b[DATA_W-1];
   assign w_a_ext  = {{DATA_W{w_a_neg}}, a};
   assign w_b_ext  = {{DATA_W{w_b_neg}}, b};
   assign w_prod   = w_a_ext * w_b_ext;
   assign w_a_mag  = w_a_neg ? -a : a;
   assign w_b_mag  = w_b_neg ? -b : b;

   div_iter #(.DATA_W(DATA_W)) u_div_iter (
      .clk         (clk),
      .rst         (rst),
      .start_i     (w_div_start),
      .abort_i     (flush),
      .dividend_i  (w_a_mag),
      .divisor_i   (w_b_mag),
      .quotient_o  (w_quo),
      .remainder_o (w_rem),
      .valid_o     (w_div_valid)
   );

   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      a_d         = a_q;
      prod_d      = prod_q;
      cnt_d       = cnt_q;
      done_d      = 1'b0;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      bzero_d     = bzero_q;
      w_div_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     state_d = MUL;
                     prod_d  = w_prod;
                     cnt_d   = MUL_LOAD;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d     = DIV;
                     w_div_start = 1'b1;
                     a_d         = a;
                     qneg_d      = w_a_neg ^ w_b_neg;
                     rneg_d      = w_a_neg;
                     bzero_d     = (b == '0);
                  end
                  OP_MTHI: begin
                     hi_d   = a;
                     done_d = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_d   = a;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d      = IDLE;
               {hi_d, lo_d} = prod_q;
               done_d       = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         DIV: begin
            if (flush) begin
               state_d = IDLE;
            end else if (w_div_valid) begin
               // Sign fix-up happens in this last cycle, between core result and commit.
               state_d = IDLE;
               done_d  = 1'b1;
               if (bzero_q) begin
                  hi_d = a_q;
                  lo_d = '1;
               end else begin
                  hi_d = rneg_q ? -w_rem : w_rem;
                  lo_d = qneg_q ? -w_quo : w_quo;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         a_q     <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         bzero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         bzero_q <= bzero_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_hilo_muldiv_unit : randomized and directed checks against an arithmetic model
// Revision : 1.0
// ============================================================================
module tb_hilo_muldiv_unit;
   import hilo_pkg::*;

   localparam int W  = 32;
   localparam int ML = 2;

   logic          clk = 1'b0;
   logic          rst, start, flush;
   logic [2:0]    op;
   logic [W-1:0]  a, b;
   logic          busy, done;
   logic [W-1:0]  hi_o, lo_o;

   int            total = 0;
   int            bad   = 0;
   logic [W-1:0]  mhi = '0;
   logic [W-1:0]  mlo = '0;

   hilo_muldiv_unit #(.DATA_W(W), .MUL_LAT(ML)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi_o  (hi_o),
      .lo_o  (lo_o)
   );

   always #5 clk = ~clk;

   // Architectural result {HI,LO} from plain integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, y,
                                              input logic [31:0] chi, clo);
      longint sx, sy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         OP_MULT: begin
            p = sx * sy;
            return 64'(p);
         end
         OP_MULTU: return {32'd0, x} * {32'd0, y};
         OP_DIV: begin
            if (y == 32'd0) return {x, 32'hFFFFFFFF};
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
            return {32'(sx % sy), 32'(sx / sy)};
         end
         OP_DIVU: begin
            if (y == 32'd0) return {x, 32'hFFFFFFFF};
            return {x % y, x / y};
         end
         OP_MTHI: return {x, clo};
         OP_MTLO: return {chi, x};
         default: return {chi, clo};
      endcase
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, y, input string name);
      logic [63:0] e;
      int          cyc;
      int          lat;
      e   = ref_result(o, x, y, mhi, mlo);
      lat = (o == OP_MULT || o == OP_MULTU) ? ML : (o == OP_DIV || o == OP_DIVU) ? W + 1 : 0;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (cyc !== lat) begin
         bad++; $display("FAIL %s latency: got %0d want %0d", name, cyc, lat);
      end
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL %s done: got %b want 1", name, done);
      end
      total++;
      if (hi_o !== e[63:32]) begin
         bad++; $display("FAIL %s hi: got %h want %h (a=%h b=%h)", name, hi_o, e[63:32], x, y);
      end
      total++;
      if (lo_o !== e[31:0]) begin
         bad++; $display("FAIL %s lo: got %h want %h (a=%h b=%h)", name, lo_o, e[31:0], x, y);
      end
      mhi = e[63:32];
      mlo = e[31:0];
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL %s after: got done=%b busy=%b want 0 0", name, done, busy);
      end
   endtask

   task automatic check_hilo(input string name);
      total++;
      if (hi_o !== mhi || lo_o !== mlo) begin
         bad++; $display("FAIL %s hilo: got %h_%h want %h_%h", name, hi_o, lo_o, mhi, mlo);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      mhi = '0; mlo = '0;
      total++;
      if (hi_o !== '0 || lo_o !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset: got hi=%h lo=%h busy=%b done=%b want all 0", hi_o, lo_o, busy, done);
      end
   endtask

   task automatic test_move();
      run_op(OP_MTHI, 32'h12345678, 32'h0, "mthi");
      run_op(OP_MTLO, 32'hCAFEF00D, 32'h0, "mtlo");
   endtask

   task automatic test_mul();
      run_op(OP_MULT,  32'hFFFFFFFE, 32'd3, "mult_neg");
      run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, "multu");
      for (int i = 0; i < 12; i++)
         run_op(($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU, $urandom, $urandom, "mul_rand");
   endtask

   task automatic test_div();
      logic [31:0] y;
      run_op(OP_DIV,  32'hFFFFFFF9, 32'd2, "div_neg");
      run_op(OP_DIVU, 32'd100, 32'd0, "divu_zero");
      run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, "div_minm1");
      run_op(OP_DIV,  32'hFFFFFFF9, 32'd0, "div_zero_neg");
      for (int i = 0; i < 10; i++) begin
         y = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         if (i % 2 == 0) y = -y;
         run_op(($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU, $urandom, y, "div_rand");
      end
   endtask

   task automatic test_flush();
      int dones;
      run_op(OP_MULTU, 32'h00001234, 32'h00010000, "pre_flush");
      start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL flush_abort: got busy=%b done=%b want 0 0", busy, done);
      end
      dones = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++; $display("FAIL flush_nodone: got %0d done pulses want 0", dones);
      end
      check_hilo("flush_keep");
      // Second start arrives only while busy and must not be queued.
      start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd6;
      @(posedge clk); #1;
      op = OP_DIVU; a = 32'd5; b = 32'd1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mhi = 32'd0; mlo = 32'd42;
      check_hilo("multu_42");
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL no_queue: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_rst_and_priority();
      start = 1'b1; op = OP_DIV; a = 32'd99; b = 32'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mhi = '0; mlo = '0;
      total++;
      if (hi_o !== '0 || lo_o !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL rst_mid: got hi=%h lo=%h busy=%b done=%b want all 0", hi_o, lo_o, busy, done);
      end
      start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
      @(posedge clk); #1;
      op = OP_MULT;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL flush_start: got busy=%b done=%b want 0 0", busy, done);
      end
      check_hilo("flush_start");
   endtask

   task automatic test_unknown();
      run_op(OP_MTLO, 32'h0BADF00D, 32'h0, "pre_unknown");
      for (int k = 6; k < 8; k++) begin
         start = 1'b1; op = 3'(k); a = 32'h11111111; b = 32'h2;
         @(posedge clk); #1;
         start = 1'b0;
         total++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL unknown_op: got busy=%b done=%b want 0 0", busy, done);
         end
         check_hilo("unknown_op");
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] o;
      for (int i = 0; i < 16; i++) begin
         o = 3'($urandom_range(0, 5));
         run_op(o, $urandom, $urandom, "b2b");
      end
   endtask

   initial begin
      test_reset();
      test_move();
      test_mul();
      test_div();
      test_flush();
      test_rst_and_priority();
      test_unknown();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
